// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - default constants and decayed-step helper for the STDP pair learner
package stdp_pkg;

  localparam int DEF_TW        = 8;
  localparam int DEF_WW        = 8;
  localparam int DEF_WINDOW    = 64;
  localparam int DEF_A_PLUS    = 16;
  localparam int DEF_A_MINUS   = 12;
  localparam int DEF_TAU_SHIFT = 3;
  localparam int DEF_W_INIT    = 128;

  // Step halves once per 2^tau cycles of interval; shifts past the weight width give zero.
  function automatic int unsigned decay_step(input int unsigned base, input int unsigned dt,
                                             input int unsigned tau, input int unsigned ww);
    int unsigned shamt;
    shamt = (dt == 0) ? 0 : ((dt - 1) >> tau);
    return (shamt >= ww) ? 0 : (base >> shamt);
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// rtl/stdp_trace.sv - spike edge detect, saturating interval counter and one-shot armed bit
module stdp_trace #(
  parameter int TW     = 8,
  parameter int WINDOW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spike,
  input  logic          consume,
  output logic          ev,
  output logic [TW-1:0] cnt,
  output logic          armed
);

  localparam logic [TW-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0] WIN     = TW'(WINDOW);

  logic          spike_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  always_comb begin
    ev      = spike & ~spike_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (ev) begin
      cnt_d   = TW'(1);
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + TW'(1);
      // Disarm as soon as the next interval would fall outside the pairing window.
      armed_d = armed_q & ~consume & (cnt_d <= WIN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= 1'b0;
      cnt_q   <= CNT_MAX;
      armed_q <= 1'b0;
    end else begin
      spike_q <= spike;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign cnt   = cnt_q;
  assign armed = armed_q;

endmodule

// File: rtl/stdp_pair_learner.sv
// rtl/stdp_pair_learner.sv - pair-based STDP: pairing decision, decayed step and saturating weight
module stdp_pair_learner
  import stdp_pkg::*;
#(
  parameter int TW        = DEF_TW,
  parameter int WW        = DEF_WW,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int A_PLUS    = DEF_A_PLUS,
  parameter int A_MINUS   = DEF_A_MINUS,
  parameter int TAU_SHIFT = DEF_TAU_SHIFT,
  parameter int W_INIT    = DEF_W_INIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pre_spike,
  input  logic          post_spike,
  input  logic          learn_en,
  output logic [WW-1:0] weight,
  output logic [TW-1:0] time_diff,
  output logic          update_w_flag,
  output logic          ltp
);

  logic          pre_ev, post_ev, pre_armed, post_armed;
  logic [TW-1:0] pre_cnt, post_cnt;
  logic          ltp_hit, ltd_hit;

  logic [WW-1:0] weight_q, weight_d;
  logic [TW-1:0] time_diff_q, time_diff_d;
  logic          flag_q, flag_d;
  logic          ltp_q, ltp_d;

  logic [TW-1:0] dt_sel;
  logic [WW:0]   delta, w_sum, w_diff;

  stdp_trace #(.TW(TW), .WINDOW(WINDOW)) u_pre_trace (
    .clk     (clk),
    .rst     (rst),
    .spike   (pre_spike),
    .consume (ltp_hit),
    .ev      (pre_ev),
    .cnt     (pre_cnt),
    .armed   (pre_armed)
  );

  stdp_trace #(.TW(TW), .WINDOW(WINDOW)) u_post_trace (
    .clk     (clk),
    .rst     (rst),
    .spike   (post_spike),
    .consume (ltd_hit),
    .ev      (post_ev),
    .cnt     (post_cnt),
    .armed   (post_armed)
  );

  // Coincident pre and post events pair with nothing; both traces just restart.
  assign ltp_hit = post_ev & ~pre_ev & pre_armed & learn_en;
  assign ltd_hit = pre_ev & ~post_ev & post_armed & learn_en;

  always_comb begin
    dt_sel = ltp_hit ? pre_cnt : post_cnt;
    delta  = (WW+1)'(decay_step(ltp_hit ? A_PLUS : A_MINUS, 32'(dt_sel), TAU_SHIFT, WW));
    w_sum  = {1'b0, weight_q} + delta;
    w_diff = {1'b0, weight_q} - delta;

    weight_d    = weight_q;
    time_diff_d = time_diff_q;
    ltp_d       = ltp_q;
    flag_d      = ltp_hit | ltd_hit;
    if (ltp_hit) begin
      weight_d    = w_sum[WW] ? '1 : w_sum[WW-1:0];
      time_diff_d = dt_sel;
      ltp_d       = 1'b1;
    end else if (ltd_hit) begin
      weight_d    = w_diff[WW] ? '0 : w_diff[WW-1:0];
      time_diff_d = dt_sel;
      ltp_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_q    <= WW'(W_INIT);
      time_diff_q <= '0;
      flag_q      <= 1'b0;
      ltp_q       <= 1'b0;
    end else begin
      weight_q    <= weight_d;
      time_diff_q <= time_diff_d;
      flag_q      <= flag_d;
      ltp_q       <= ltp_d;
    end
  end

  assign weight        = weight_q;
  assign time_diff     = time_diff_q;
  assign update_w_flag = flag_q;
  assign ltp           = ltp_q;

endmodule
